// File: rtl/jk_cmd_sequencer.sv
// Buffers hold/clear/set/toggle commands and replays each as registered j,k for cnt+1 cycles,
// tracking the downstream JK flip-flop's q. Define JKSEQ_CHECK_EN to add the q_obs/mismatch checker.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd,
  input  logic [CW-1:0] cnt,
  output logic          j,
  output logic          k,
  output logic          busy,
  output logic          q_model
`ifdef JKSEQ_CHECK_EN
  ,
  input  logic          q_obs,
  output logic          mismatch
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 2 + CW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [0:0]    state_reg;
  logic [CW-1:0] remaining_reg;
  logic          j_reg, k_reg, q_reg;

  logic          empty, push, pop;
  logic [EW-1:0] head;
  logic          q_next;

  assign empty     = (count_reg == '0);
  assign cmd_ready = (count_reg != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  // Pop whenever the current command is on its last cycle (or nothing runs), so commands abut.
  assign pop       = !empty && ((state_reg == IDLE) || (remaining_reg == '0));
  assign head      = mem[rd_ptr_reg];

  assign j       = j_reg;
  assign k       = k_reg;
  assign q_model = q_reg;
  assign busy    = (state_reg == RUN) || !empty;

  always_comb begin
    q_next = q_reg;
    case ({j_reg, k_reg})
      2'b00:   q_next = q_reg;
      2'b01:   q_next = 1'b0;
      2'b10:   q_next = 1'b1;
      default: q_next = ~q_reg;
    endcase
  end

  // Storage carries no reset: stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {cmd, cnt};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      j_reg         <= 1'b0;
      k_reg         <= 1'b0;
      q_reg         <= 1'b0;
    end else begin
      q_reg <= q_next;
      if (pop) begin
        {j_reg, k_reg} <= head[EW-1 -: 2];
        remaining_reg  <= head[CW-1:0];
        state_reg      <= RUN;
      end else if ((state_reg == RUN) && (remaining_reg != '0)) begin
        remaining_reg <= remaining_reg - CW'(1);
      end else begin
        j_reg     <= 1'b0;
        k_reg     <= 1'b0;
        state_reg <= IDLE;
      end
    end
  end

`ifdef JKSEQ_CHECK_EN
  logic mismatch_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mismatch_reg <= 1'b0;
    else if (q_obs != q_reg) mismatch_reg <= 1'b1;
  end

  assign mismatch = mismatch_reg;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: directed steps plus random traffic against a command-stream model.
// Also exercises the q_obs/mismatch checker when JKSEQ_CHECK_EN is defined.
module tb_jk_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd = 2'b00;
  logic [CW-1:0] cnt = '0;
  logic          j, k, busy, q_model;
`ifdef JKSEQ_CHECK_EN
  logic          q_obs, mismatch, ff_q;
  logic          inv = 1'b0;
  logic          m_mis;
`endif

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cnt(cnt), .j(j), .k(k), .busy(busy), .q_model(q_model)
`ifdef JKSEQ_CHECK_EN
    , .q_obs(q_obs), .mismatch(mismatch)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    case (jk)
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

`ifdef JKSEQ_CHECK_EN
  always @(posedge clk or negedge rst) begin
    if (!rst) ff_q <= 1'b0;
    else      ff_q <= jk_next(ff_q, {j, k});
  end
  assign q_obs = ff_q ^ inv;
`endif

  // Model: queued commands, plus the expanded per-cycle (j,k) stream of the command in flight.
  typedef struct packed { logic [1:0] c; logic [CW-1:0] n; } ent_t;
  ent_t       fifo_q[$];
  logic [1:0] drive_q[$];
  logic [1:0] m_jk;
  logic       m_active;
  logic       m_q;

  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    fifo_q.delete();
    drive_q.delete();
    m_jk = 2'b00;
    m_active = 1'b0;
    m_q = 1'b0;
`ifdef JKSEQ_CHECK_EN
    m_mis = 1'b0;
`endif
  endtask

  task automatic model_edge(input logic v, input logic [1:0] c, input logic [CW-1:0] n, input logic qo);
    int pre;
    ent_t h;
    pre = fifo_q.size();
`ifdef JKSEQ_CHECK_EN
    if (qo !== m_q) m_mis = 1'b1;
`endif
    m_q = jk_next(m_q, m_jk);
    if (drive_q.size() > 0) begin
      m_jk = drive_q.pop_front();
      m_active = 1'b1;
    end else if (pre > 0) begin
      h = fifo_q.pop_front();
      m_jk = h.c;
      for (int i = 0; i < int'(h.n); i++) drive_q.push_back(h.c);
      m_active = 1'b1;
    end else begin
      m_jk = 2'b00;
      m_active = 1'b0;
    end
    if (v && pre < DEPTH) begin
      h.c = c;
      h.n = n;
      fifo_q.push_back(h);
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic bound_ok(input string tag, input bit ok);
    vectors++;
    assert (ok) else begin
      miscompares++;
      $error("FAIL %s: observed cycle budget expired expected completion", tag);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".j"}, j, m_jk[1]);
    chk({tag, ".k"}, k, m_jk[0]);
    chk({tag, ".q_model"}, q_model, m_q);
    chk({tag, ".busy"}, busy, m_active || (fifo_q.size() != 0));
    chk({tag, ".cmd_ready"}, cmd_ready, fifo_q.size() < DEPTH);
`ifdef JKSEQ_CHECK_EN
    chk({tag, ".mismatch"}, mismatch, m_mis);
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 after it.
  task automatic step(input string tag, input logic v, input logic [1:0] c, input logic [CW-1:0] n);
    logic qo;
    cmd_valid = v;
    cmd = c;
    cnt = n;
    qo = 1'b0;
`ifdef JKSEQ_CHECK_EN
    qo = q_obs;
`endif
    @(posedge clk);
    model_edge(v, c, n, qo);
    #1;
    check_all(tag);
    cmd_valid = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  logic [1:0] b2b_cmd [3] = '{2'b11, 2'b01, 2'b10};
  logic [3:0] b2b_cnt [3] = '{4'd3, 4'd0, 4'd1};
  logic [1:0] b2b_jk  [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b10, 2'b00};
  logic       b2b_q   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int pushed;
    int tries;
    logic [1:0] rc;
    logic [CW-1:0] rn;

    // Reset held for two cycles, then idle.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step("idle", 1'b0, 2'b00, '0);

    // Back-to-back toggle/clear/set with literal expectations.
    for (int i = 0; i < 9; i++) begin
      if (i < 3) step("b2b", 1'b1, b2b_cmd[i], b2b_cnt[i]);
      else       step("b2b", 1'b0, 2'b00, '0);
      if (i >= 1) begin
        chk("b2b_lit.j", j, b2b_jk[i-1][1]);
        chk("b2b_lit.k", k, b2b_jk[i-1][0]);
        chk("b2b_lit.q", q_model, b2b_q[i-1]);
      end
    end

    // Single set with cnt=2.
    step("set", 1'b1, 2'b10, 4'd2);
    for (int i = 0; i < 6; i++) step("set", 1'b0, 2'b00, '0);

    // Long toggle, then five more commands against a four-entry FIFO.
    step("full", 1'b1, 2'b11, 4'd15);
    pushed = 0;
    tries = 0;
    rc = 2'($urandom);
    rn = CW'($urandom_range(0, 3));
    while (pushed < 5 && tries < 60) begin
      if (fifo_q.size() < DEPTH) begin
        step("full", 1'b1, rc, rn);
        pushed++;
        rc = 2'($urandom);
        rn = CW'($urandom_range(0, 3));
      end else begin
        step("full", 1'b1, rc, rn);
      end
      tries++;
    end
    bound_ok("full.push_budget", pushed == 5);
    tries = 0;
    while ((m_active || fifo_q.size() != 0) && tries < 200) begin
      step("drain", 1'b0, 2'b00, '0);
      tries++;
    end
    bound_ok("drain.budget", tries < 200);

    // Reset in the middle of a long toggle with two entries queued.
    step("mid", 1'b1, 2'b11, 4'd10);
    step("mid", 1'b1, 2'b10, 4'd3);
    step("mid", 1'b1, 2'b01, 4'd2);
    step("mid", 1'b0, 2'b00, '0);
    async_reset("mid_arst");
    for (int i = 0; i < 15; i++) step("post_arst", 1'b0, 2'b00, '0);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_arst");
      end else begin
        rc = 2'($urandom);
        rn = ($urandom_range(0, 7) == 0) ? CW'(15) : CW'($urandom_range(0, 3));
        step("rnd", ($urandom_range(0, 2) != 0), rc, rn);
      end
    end

`ifdef JKSEQ_CHECK_EN
    // Invert the observed q for one cycle; the flag must latch and hold.
    inv = 1'b1;
    step("inv", 1'b0, 2'b00, '0);
    inv = 1'b0;
    chk("mismatch_set", mismatch, 1'b1);
    for (int i = 0; i < 3; i++) step("inv_hold", 1'b0, 2'b00, '0);
    async_reset("inv_arst");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream driver for the team's JK flip-flop stage.
- Accepts buffered set/clear/toggle/hold commands over a valid/ready interface and replays each one as registered j,k levels for a programmable number of consecutive cycles.
- Keeps a cycle-accurate model of the downstream flip-flop's q.
- Lets sequenced JK stimulus be produced in hardware rather than by hand-written waveforms.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- CW, 4, width of the per-command repeat count.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd  input  2  00 hold, 01 clear, 10 set, 11 toggle.
- cnt  input  CW  repeat count; command drives for cnt+1 cycles.
- j  output  1  registered J to downstream flip-flop.
- k  output  1  registered K to downstream flip-flop.
- busy  output  1  1 when in RUN or FIFO non-empty.
- q_model  output  1  predicted downstream q.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - FIFO flushed (rd/wr pointers 0, count 0).
  - state=IDLE, remaining=0.
  - j=0, k=0, q_model=0, cmd_ready=1, busy=0.
- Reset mid-operation: in-flight and queued commands are discarded with no replay after release. Deassertion takes effect at the next posedge.
- FIFO:
  - Push on posedge when cmd_valid && cmd_ready.
  - Entry = {cmd, cnt}, width 2+CW.
  - cmd_ready = (count != DEPTH).
  - When full, cmd_ready=0 even if a pop occurs that same cycle; no push-through.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo DEPTH.
- Commands map to (j,k) as follows: hold=(0,0), clear=(0,1), set=(1,0), toggle=(1,1).
- State machine, IDLE:
  - If FIFO non-empty: pop, load j,k from the popped cmd, remaining<=cnt, go RUN.
  - Else j=k=0.
- State machine, RUN:
  - If remaining!=0: remaining<=remaining-1; j,k unchanged.
  - If remaining==0 and FIFO non-empty: pop the next entry, load it, stay in RUN. Back-to-back, no bubble cycle.
  - If remaining==0 and FIFO empty: j<=0, k<=0, go IDLE.
- Timing:
  - A command pushed into an empty, idle FIFO at edge E drives j,k from edge E+1 through edge E+1+cnt.
  - j=k=0 from edge E+2+cnt unless another command follows.
- cnt=0 gives exactly one cycle. cnt=2^CW-1 gives 2^CW cycles; no overflow, remaining only decrements.
- q_model: at every posedge, updated from the current registered j,k using the JK rules (00 hold, 01 ->0, 10 ->1, 11 invert). This tracks a flip-flop on the same clock whose reset is tied to the same reset event.
- busy = (state==RUN) || (count!=0).

Optional Feature:
- Macro JKSEQ_CHECK_EN.
- When defined:
  - Adds input q_obs (1 bit, the downstream flip-flop q) and output mismatch (1 bit).
  - mismatch is a sticky register: reset to 0, set at any posedge where q_obs != q_model, cleared only by reset.
- When undefined: neither port exists, no compare logic is present, and all other behaviour is identical.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> j=k=0, q_model=0, cmd_ready=1, busy=0 for 5 cycles.
- Single set: push cmd=10, cnt=2 at edge E -> j=1,k=0 after edges E+1..E+3; j=k=0 after E+4; q_model=1 from E+2 onward; busy falls after E+4.
- Back-to-back: push toggle cnt=3, then clear cnt=0, then set cnt=1 on consecutive cycles -> j,k sequence 11,11,11,11,01,10,10,00 with no gaps; q_model 0,1,0,1,0,0,1,1 at the successive edges.
- Full FIFO: push 5 commands (DEPTH=4) while the first is running with cnt=15 -> cmd_ready=0 after the 4th queued entry; the 5th is accepted only after the next pop; all commands replay in order.
- Reset mid-run: assert rst during a toggle with cnt=10 and 2 entries queued -> j,k,q_model,busy go 0 immediately with no clock; after release nothing replays.
- With JKSEQ_CHECK_EN, connect a JK flip-flop on the same clk/reset: run the back-to-back sequence -> mismatch stays 0. Then force q_obs to the inverse for one cycle -> mismatch=1 and stays 1 until reset.
